// File: rtl/score_bcd_converter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : score_bcd_converter_if
// Brief   : Start/Value request and BCD result bundle for score_bcd_converter.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
interface score_bcd_converter_if #(
    parameter int WIDTH = 7
);
    logic             Start;
    logic [WIDTH-1:0] Value;
    logic [3:0]       Tens;
    logic [3:0]       Ones;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Value,
        input  Tens, Ones, Overflow, Busy, Done
    );

    modport slave (
        input  Start, Value,
        output Tens, Ones, Overflow, Busy, Done
    );
endinterface
`default_nettype wire

// File: rtl/score_bcd_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : score_bcd_converter
// Brief   : Iterative double-dabble binary-to-two-digit-BCD converter, one bit
//           per clock. Define SCORE_BCD_SATURATE_EN to pin the display at 99
//           on overflow; otherwise the digits show Value mod 100.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module score_bcd_converter #(
    parameter int WIDTH = 7
) (
    input  wire                   Clock,
    input  wire                   Resetn,
    score_bcd_converter_if.slave  bus
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_shreg;
    logic [7:0]         r_scratch;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_tens;
    logic [3:0]         r_ones;
    logic               r_ovf;

    logic [7:0]         w_adj;
    logic [7:0]         w_scr_shift;
    logic [WIDTH-1:0]   w_sh_shift;
    logic               w_carry_next;
    logic               w_last;
    logic [3:0]         w_res_tens;
    logic [3:0]         w_res_ones;

    // Nibble correction is a plain 4-bit add; a corrected digit never exceeds 12.
    always_comb begin
        w_adj = r_scratch;
        if (r_scratch[3:0] >= 4'd5) begin
            w_adj[3:0] = r_scratch[3:0] + 4'd3;
        end
        if (r_scratch[7:4] >= 4'd5) begin
            w_adj[7:4] = r_scratch[7:4] + 4'd3;
        end
    end

    assign w_scr_shift  = {w_adj[6:0], r_shreg[WIDTH-1]};
    assign w_sh_shift   = {r_shreg[WIDTH-2:0], 1'b0};
    assign w_carry_next = r_carry | w_adj[7];
    assign w_last       = (r_cnt == c_CNT_ONE);

`ifdef SCORE_BCD_SATURATE_EN
    assign w_res_tens = w_carry_next ? 4'd9 : w_scr_shift[7:4];
    assign w_res_ones = w_carry_next ? 4'd9 : w_scr_shift[3:0];
`else
    assign w_res_tens = w_scr_shift[7:4];
    assign w_res_ones = w_scr_shift[3:0];
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.Start) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_next = S_DONE;
            S_DONE:                 w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Results load on the final shift edge so they are visible throughout DONE.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_tens    <= '0;
            r_ones    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_shreg   <= bus.Value;
                        r_scratch <= '0;
                        r_carry   <= 1'b0;
                        r_cnt     <= c_CNT_LOAD;
                    end
                end
                S_SHIFT: begin
                    r_shreg   <= w_sh_shift;
                    r_scratch <= w_scr_shift;
                    r_carry   <= w_carry_next;
                    r_cnt     <= r_cnt - c_CNT_ONE;
                    if (w_last) begin
                        r_tens <= w_res_tens;
                        r_ones <= w_res_ones;
                        r_ovf  <= w_carry_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Tens     = r_tens;
    assign bus.Ones     = r_ones;
    assign bus.Overflow = r_ovf;
    assign bus.Busy     = (r_state != S_IDLE);
    assign bus.Done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_score_bcd_converter
// Brief   : Randomised self-checking bench for score_bcd_converter.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_score_bcd_converter;

    localparam int WIDTH = 7;
    localparam int LAT   = WIDTH + 1;

    logic Clock;
    logic Resetn;
    int   checks;
    int   failures;

    score_bcd_converter_if #(.WIDTH(WIDTH)) bus ();

    score_bcd_converter #(.WIDTH(WIDTH)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic void ref_model(input int v, output logic [3:0] t,
                                      output logic [3:0] o, output logic ov);
        int m;
        ov = (v >= 100);
        m  = v % 100;
        t  = 4'(m / 10);
        o  = 4'(m % 10);
`ifdef SCORE_BCD_SATURATE_EN
        if (ov) begin
            t = 4'd9;
            o = 4'd9;
        end
`endif
    endfunction

    // Drives a single Start pulse and measures latency, busy span and result.
    task automatic run_conv(input int v, output int lat, output int bcnt,
                            output logic [3:0] t, output logic [3:0] o, output logic ov);
        lat = 0; bcnt = 0; t = '0; o = '0; ov = 1'b0;
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Value = WIDTH'(v);
        @(negedge Clock);
        bus.Start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.Busy) bcnt++;
            if (bus.Done && lat == 0) begin
                lat = k; t = bus.Tens; o = bus.Ones; ov = bus.Overflow;
            end
            if (lat != 0 && !bus.Busy) break;
            @(negedge Clock);
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; bus.Start = 1'b0; bus.Value = '0;
        repeat (3) @(negedge Clock);
        checks++;
        if ({bus.Tens, bus.Ones, bus.Overflow, bus.Busy, bus.Done} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=0",
                     {bus.Tens, bus.Ones, bus.Overflow, bus.Busy, bus.Done});
        end
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_basic();
        int lat, bcnt; logic [3:0] t, o; logic ov;
        run_conv(42, lat, bcnt, t, o, ov);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL basic_latency got=%0d expected=%0d", lat, LAT); end
        checks++;
        if (bcnt !== LAT) begin failures++; $display("FAIL basic_busy got=%0d expected=%0d", bcnt, LAT); end
        checks++;
        if ({t, o, ov} !== {4'd4, 4'd2, 1'b0}) begin
            failures++; $display("FAIL basic_result got=%0d/%0d/%0d expected=4/2/0", t, o, ov);
        end
    endtask

    task automatic test_zero_99();
        int lat, bcnt; logic [3:0] t, o; logic ov;
        run_conv(0, lat, bcnt, t, o, ov);
        checks++;
        if ({t, o, ov} !== 9'd0 || lat !== LAT) begin
            failures++; $display("FAIL zero_result got=%0d/%0d/%0d lat=%0d expected=0/0/0 lat=%0d", t, o, ov, lat, LAT);
        end
        run_conv(99, lat, bcnt, t, o, ov);
        checks++;
        if ({t, o, ov} !== {4'd9, 4'd9, 1'b0} || lat !== LAT) begin
            failures++; $display("FAIL ninety_nine got=%0d/%0d/%0d lat=%0d expected=9/9/0 lat=%0d", t, o, ov, lat, LAT);
        end
        bus.Value = WIDTH'(3);
        repeat (6) @(negedge Clock);
        checks++;
        if ({bus.Tens, bus.Ones, bus.Overflow} !== {4'd9, 4'd9, 1'b0}) begin
            failures++; $display("FAIL hold_outputs got=%0d/%0d/%0d expected=9/9/0", bus.Tens, bus.Ones, bus.Overflow);
        end
    endtask

    task automatic test_overflow();
        int lat, bcnt; logic [3:0] t, o, et, eo; logic ov, eov;
        int vals[2] = '{127, 100};
        foreach (vals[i]) begin
            ref_model(vals[i], et, eo, eov);
            run_conv(vals[i], lat, bcnt, t, o, ov);
            checks++;
            if ({t, o, ov} !== {et, eo, eov} || lat !== LAT) begin
                failures++;
                $display("FAIL overflow_%0d got=%0d/%0d/%0d lat=%0d expected=%0d/%0d/%0d lat=%0d",
                         vals[i], t, o, ov, lat, et, eo, eov, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Value = WIDTH'(57);
        @(negedge Clock);
        for (int k = 1; k <= 27; k++) begin
            logic exp_done;
            exp_done = (k == 8) || (k == 17) || (k == 26);
            checks++;
            if (bus.Done !== exp_done) begin
                failures++; $display("FAIL b2b_done_k%0d got=%b expected=%b", k, bus.Done, exp_done);
            end
            if (bus.Done) begin
                dones++;
                checks++;
                if ({bus.Tens, bus.Ones, bus.Overflow} !== {4'd5, 4'd7, 1'b0}) begin
                    failures++; $display("FAIL b2b_result got=%0d/%0d/%0d expected=5/7/0", bus.Tens, bus.Ones, bus.Overflow);
                end
            end
            @(negedge Clock);
        end
        bus.Start = 1'b0;
        checks++;
        if (dones !== 3) begin failures++; $display("FAIL b2b_count got=%0d expected=3", dones); end
        for (int k = 0; k < 20 && bus.Busy; k++) @(negedge Clock);
    endtask

    task automatic test_ignore_start();
        logic seen;
        seen = 1'b0;
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Value = WIDTH'(57);
        @(negedge Clock);
        // Start stays high with shifting garbage until the DONE cycle, then drops.
        for (int k = 1; k <= LAT; k++) begin
            if (bus.Done) begin
                seen = 1'b1;
                checks++;
                if ({bus.Tens, bus.Ones} !== {4'd5, 4'd7} || k !== LAT) begin
                    failures++; $display("FAIL ignore_result got=%0d/%0d k=%0d expected=5/7 k=%0d", bus.Tens, bus.Ones, k, LAT);
                end
            end
            bus.Value = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            bus.Start = (k < LAT);
            @(negedge Clock);
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL ignore_done got=0 expected=1"); end
        repeat (3) begin
            checks++;
            if (bus.Busy !== 1'b0) begin failures++; $display("FAIL ignore_queued busy got=%b expected=0", bus.Busy); end
            @(negedge Clock);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt; logic [3:0] t, o; logic ov; logic spurious;
        spurious = 1'b0;
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Value = WIDTH'(88);
        @(negedge Clock);
        bus.Start = 1'b0;
        repeat (3) @(negedge Clock);
        Resetn = 1'b0;
        #1;
        checks++;
        if ({bus.Tens, bus.Ones, bus.Overflow, bus.Busy, bus.Done} !== 11'd0) begin
            failures++; $display("FAIL abort_outputs got=%b expected=0",
                                 {bus.Tens, bus.Ones, bus.Overflow, bus.Busy, bus.Done});
        end
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        repeat (12) begin
            if (bus.Done || bus.Busy) spurious = 1'b1;
            @(negedge Clock);
        end
        checks++;
        if (spurious) begin failures++; $display("FAIL abort_no_done got=1 expected=0"); end
        run_conv(13, lat, bcnt, t, o, ov);
        checks++;
        if ({t, o, ov} !== {4'd1, 4'd3, 1'b0} || lat !== LAT) begin
            failures++; $display("FAIL after_abort got=%0d/%0d/%0d lat=%0d expected=1/3/0 lat=%0d", t, o, ov, lat, LAT);
        end
    endtask

    task automatic test_sweep();
        int lat, bcnt, v; logic [3:0] t, o, et, eo; logic ov, eov;
        for (int n = 0; n < (1 << WIDTH) + 40; n++) begin
            v = (n < (1 << WIDTH)) ? n : int'($urandom_range(0, (1 << WIDTH) - 1));
            ref_model(v, et, eo, eov);
            run_conv(v, lat, bcnt, t, o, ov);
            checks++;
            if ({t, o, ov} !== {et, eo, eov} || lat !== LAT || bcnt !== LAT) begin
                failures++;
                $display("FAIL sweep_%0d got=%0d/%0d/%0d lat=%0d busy=%0d expected=%0d/%0d/%0d lat=%0d busy=%0d",
                         v, t, o, ov, lat, bcnt, et, eo, eov, LAT, LAT);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_zero_99();
        test_overflow();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_bcd_converter.md
# score_bcd_converter

Sequential binary-to-BCD converter for the physical score display. It takes an unsigned binary score from the game logic and produces a tens digit and a ones digit, one BCD nibble each. The nibbles feed the existing per-digit hex decoders, so two-digit scores show in decimal instead of hexadecimal. The conversion is iterative shift-and-add-3 (double dabble), one input bit per clock, with a Start/Done handshake.

## Interface
- WIDTH, 7: width of the binary input, legal range 4–10; the default covers scores 0–127.
- Clock  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Start  input  1  request conversion of Value; sampled only in IDLE.
- Value  input  WIDTH  unsigned binary score; captured on the accepting edge.
- Tens  output  4  BCD tens digit of the last completed conversion.
- Ones  output  4  BCD ones digit of the last completed conversion.
- Overflow  output  1  last completed conversion had Value > 99.
- Busy  output  1  high in SHIFT and DONE.
- Done  output  1  single-cycle pulse marking that Tens/Ones/Overflow have just updated.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE, Start=1 at an edge:
  - capture Value into the shift register;
  - clear the 8-bit BCD scratch register and the sticky carry bit;
  - load the bit counter with WIDTH;
  - go to SHIFT.
- IDLE, Start=0: stay in IDLE.
- Each SHIFT cycle:
  - add 3 to each scratch nibble that is ≥5;
  - shift {scratch, shift register} left by one, MSB of Value first;
  - OR the bit shifted out of scratch bit 7 into the sticky carry;
  - decrement the counter; after the WIDTH-th shift, go to DONE.
- DONE, for one cycle:
  - load Tens, Ones and Overflow;
  - assert Done;
  - return to IDLE.
- Overflow = sticky carry OR (scratch digit ≥10 is impossible by construction). In effect, Overflow=1 exactly when Value ≥ 100.
- Start outside IDLE (SHIFT or DONE) is ignored, not queued. Value changes after capture have no effect.
- Tens, Ones and Overflow hold their values between DONE cycles. They are never partially updated.
- Assertion of Resetn mid-conversion aborts immediately:
  - state goes to IDLE;
  - all outputs and internal registers go to 0;
  - a conversion in flight produces no Done.
- Arithmetic: the nibble correction is a 4-bit add with no carry into the next nibble. Truncating scratch to two digits leaves the low digits equal to Value mod 100.

## Timing
- Reset values: Tens=0, Ones=0, Overflow=0, Busy=0, Done=0.
- Start accepted at edge E0. Busy goes high after E0.
- SHIFT covers edges E1..E_WIDTH. DONE is the cycle after E_WIDTH.
- Done is high and the new results are visible in the cycle following edge E_WIDTH. Latency from the accepting edge to Done is WIDTH+1 cycles; for WIDTH=7 that is 8.
- Busy falls on the edge that ends DONE, together with Done.
- The earliest next accept is the edge after the Done cycle. Sustained throughput is one conversion per WIDTH+2 cycles.
- Resetn is asynchronous on assertion. The deassertion edge is synchronised externally; the block assumes clean release.

## Configuration
- SCORE_BCD_SATURATE_EN defined:
  - when Overflow is 1, Tens and Ones are forced to 9/9 in DONE;
  - the display pins at 99.
- SCORE_BCD_SATURATE_EN undefined:
  - Tens/Ones show Value mod 100;
  - Overflow is still reported.
- No other behaviour, latency or port differs between the two builds.

## Test plan
- Reset, then Value=42 with a Start pulse → Busy high for 8 cycles; Done pulses 8 cycles after the accepting edge with Tens=4, Ones=2, Overflow=0.
- Value=0, then Value=99 in consecutive conversions → 0/0 then 9/9, Overflow=0 both times. Outputs hold between conversions.
- Value=127 → Overflow=1; Tens/Ones=9/9 with SCORE_BCD_SATURATE_EN, 2/7 without. Repeat for Value=100 → 9/9 or 0/0 respectively.
- Start held high continuously with Value=57 → conversions accepted every 9 cycles. Start during SHIFT/DONE is ignored, and a Value change mid-conversion does not alter the result 5/7.
- Resetn asserted at the 4th SHIFT cycle of Value=88 → all outputs 0 immediately, no Done pulse. After release, Start with Value=13 → 1/3 with normal latency.
- Sweep Value 0–127 against a reference model (mod 100 or saturate per build) → every result and every Done timing matches.
